// File: rtl/video_shifter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// video_shifter
//
// Pixel output stage that sits directly after video_gen. It captures the
// screen code fetched from video RAM, forms the character ROM address,
// captures the glyph row fetched from the ROM and shifts it out MSB-first,
// one pixel per pixel_en. Reverse video (code bit 7), global inversion and
// blanking are applied on the way out. The sync inputs and the display-enable
// pass through the same one-character pipeline stage as the pixels, so they
// stay aligned with the cell they frame.
//
// Ports
//   clk16             in   16 MHz system clock
//   reset_n           in   asynchronous active-low reset
//   pixel_en          in   pixel-rate enable, one clk16 wide, every 2nd clk16
//   video_ram_strobe  in   data_in carries the screen code this cycle
//   video_rom_strobe  in   data_in carries the glyph row this cycle
//   data_in[7:0]      in   shared fetch data bus
//   ra[ROW_BITS-1:0]  in   glyph row within the character cell
//   graphic           in   character-set select (ROM address MSB)
//   invert            in   global screen inversion
//   h_active,v_active in   display-enable inputs
//   h_sync,v_sync     in   sync inputs
//   rom_addr          out  {graphic, code[6:0], ra}
//   video             out  serialized pixel, 1 = lit
//   h_sync_out        out  h_sync delayed one character time
//   v_sync_out        out  v_sync delayed one character time
//   underrun          out  sticky: a cell was loaded with no glyph fetched
// -----------------------------------------------------------------------------
module video_shifter #(
    parameter int CHAR_WIDTH = 8,
    parameter int ROW_BITS   = 3
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    input  logic                  pixel_en,
    input  logic                  video_ram_strobe,
    input  logic                  video_rom_strobe,
    input  logic [7:0]            data_in,
    input  logic [ROW_BITS-1:0]   ra,
    input  logic                  graphic,
    input  logic                  invert,
    input  logic                  h_active,
    input  logic                  v_active,
    input  logic                  h_sync,
    input  logic                  v_sync,
    output logic [ROW_BITS+7:0]   rom_addr,
    output logic                  video,
    output logic                  h_sync_out,
    output logic                  v_sync_out,
    output logic                  underrun
);

    localparam int              CW       = (CHAR_WIDTH > 2) ? $clog2(CHAR_WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CHAR_WIDTH - 1);

    // Fetch-side registers (next cell)
    logic [6:0]    code;
    logic          rev_next;
    logic [7:0]    glyph_next;
    logic          pend;

    // Display-side registers (current cell)
    logic [CW-1:0] cnt;
    logic          act_prev;
    logic [7:0]    shreg;
    logic          rev;
    logic          act_d;
    logic          hs_d;
    logic          vs_d;

    logic          ram_cap;
    logic          rom_cap;
    logic          active_now;
    logic          active_rise;
    logic          load;

    logic [7:0]    sh_next;
    logic          rev_sel;
    logic          act_sel;

    // A RAM strobe always wins; a ROM strobe in the same cycle is discarded.
    assign ram_cap     = video_ram_strobe;
    assign rom_cap     = video_rom_strobe & ~video_ram_strobe;

    assign active_now  = h_active & v_active;
    // act_prev holds the display-enable seen at the previous pixel_en.
    assign active_rise = active_now & ~act_prev;
    assign load        = pixel_en & ((cnt == CNT_LAST) | active_rise);

    // ------------------------------------------------------------------
    // Code capture and ROM address
    // ------------------------------------------------------------------
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            code     <= '0;
            rev_next <= 1'b0;
        end else if (ram_cap) begin
            code     <= data_in[6:0];
            rev_next <= data_in[7];
        end
    end

    // Loaded straight from the bus on the strobe so the address is valid one
    // clk16 after it; otherwise it follows graphic/ra against the held code.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
        end else if (ram_cap) begin
            rom_addr <= {graphic, data_in[6:0], ra};
        end else begin
            rom_addr <= {graphic, code, ra};
        end
    end

    // ------------------------------------------------------------------
    // Glyph capture and pending flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            glyph_next <= 8'h00;
        end else if (rom_cap) begin
            glyph_next <= data_in;
        end
    end

    // A glyph arriving on the same edge as a load belongs to the next cell,
    // so the set takes priority over the clear.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            pend <= 1'b0;
        end else begin
            if (load) begin
                pend <= 1'b0;
            end
            if (rom_cap) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (load && !pend) begin
            underrun <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pixel counter; the first rise of the display-enable realigns the cell
    // grid so that the rise pixel is the first pixel of a cell.
    // ------------------------------------------------------------------
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            act_prev <= 1'b0;
        end else if (pixel_en) begin
            act_prev <= active_now;
            if (active_rise || (cnt == CNT_LAST)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state of the display pipeline. The video register is computed
    // from these next values so the first pixel of a cell appears on the
    // same edge that loads the cell and its syncs.
    // ------------------------------------------------------------------
    always_comb begin
        sh_next = {shreg[6:0], 1'b0};
        rev_sel = rev;
        act_sel = act_d;
        if (load) begin
            sh_next = pend ? glyph_next : 8'h00;
            rev_sel = rev_next;
            act_sel = active_now;
        end
    end

    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= 8'h00;
            rev   <= 1'b0;
            act_d <= 1'b0;
            video <= 1'b0;
        end else if (pixel_en) begin
            shreg <= sh_next;
            rev   <= rev_sel;
            act_d <= act_sel;
            // Blanked cells stay dark whatever the reverse/invert state.
            video <= act_sel & (sh_next[7] ^ rev_sel ^ invert);
        end
    end

    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            hs_d <= 1'b0;
            vs_d <= 1'b0;
        end else if (load) begin
            hs_d <= h_sync;
            vs_d <= v_sync;
        end
    end

    assign h_sync_out = hs_d;
    assign v_sync_out = vs_d;

endmodule

// File: tb/tb_video_shifter.sv
`timescale 1ns/1ps
module tb_video_shifter;

    logic        clk16;
    logic        reset_n;
    logic        pixel_en;
    logic        video_ram_strobe;
    logic        video_rom_strobe;
    logic [7:0]  data_in;
    logic [2:0]  ra;
    logic        graphic;
    logic        invert;
    logic        h_active;
    logic        v_active;
    logic        h_sync;
    logic        v_sync;
    logic [10:0] rom_addr;
    logic        video;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        underrun;

    video_shifter #(.CHAR_WIDTH(8), .ROW_BITS(3)) dut (
        .clk16            (clk16),
        .reset_n          (reset_n),
        .pixel_en         (pixel_en),
        .video_ram_strobe (video_ram_strobe),
        .video_rom_strobe (video_rom_strobe),
        .data_in          (data_in),
        .ra               (ra),
        .graphic          (graphic),
        .invert           (invert),
        .h_active         (h_active),
        .v_active         (v_active),
        .h_sync           (h_sync),
        .v_sync           (v_sync),
        .rom_addr         (rom_addr),
        .video            (video),
        .h_sync_out       (h_sync_out),
        .v_sync_out       (v_sync_out),
        .underrun         (underrun)
    );

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    typedef struct packed {
        logic act;
        logic pix;
    } pix_t;

    pix_t vq[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   hs_rise_cyc = 0;
    logic exp_hs   = 1'b0;
    logic exp_vs   = 1'b0;
    logic exp_unr  = 1'b0;
    logic hso_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic prime_queue();
        vq.delete();
        for (int k = 0; k < 7; k++) vq.push_back('{act: 1'b0, pix: 1'b0});
    endtask

    // One character time of fetch activity. The cell fetched here is loaded
    // on the final (phase 0) edge; its pixels come out during the next call.
    task automatic run_cell(input logic ha, input logic va, input logic hs, input logic vs,
                            input logic inv, input logic gr, input logic [2:0] rav,
                            input logic [7:0] code_v, input logic [7:0] glyph_v,
                            input logic do_rom, input logic do_both, input logic [7:0] both_v);
        logic [7:0] g;
        logic       rv;
        pix_t       e;
        g  = do_rom ? glyph_v : 8'h00;
        rv = do_both ? both_v[7] : code_v[7];
        for (int k = 0; k < 8; k++) vq.push_back('{act: ha & va, pix: g[7-k] ^ rv});
        for (int i = 0; i < 16; i++) begin
            int ph;
            ph = (i + 1) % 16;
            if (i == 0) begin
                if (hs && !h_sync) hs_rise_cyc = cyc;
                h_sync  = hs;
                v_sync  = vs;
                invert  = inv;
                graphic = gr;
                ra      = rav;
            end
            if (i == 14) begin
                h_active = ha;
                v_active = va;
            end
            pixel_en         = (ph % 2 == 0);
            video_ram_strobe = (ph == 3) || (do_both && ph == 9);
            video_rom_strobe = (do_rom && ph == 7) || (do_both && ph == 9);
            data_in          = (ph == 3) ? code_v : (ph == 7) ? glyph_v :
                               (ph == 9) ? both_v : 8'($urandom);
            @(negedge clk16);
            cyc++;
            if (pixel_en) begin
                chk("vq_nonempty", 32'(vq.size() != 0), 32'd1);
                if (vq.size() != 0) begin
                    e = vq.pop_front();
                    chk($sformatf("video@cyc%0d", cyc), 32'(video), 32'(e.act & (e.pix ^ invert)));
                end
            end
            if (ph == 4)
                chk("rom_addr", 32'(rom_addr), 32'({gr, code_v[6:0], rav}));
            if (ph == 10 && do_both)
                chk("rom_addr_both", 32'(rom_addr), 32'({gr, both_v[6:0], rav}));
            if (ph == 8) begin
                chk("h_sync_mid", 32'(h_sync_out), 32'(exp_hs));
                chk("v_sync_mid", 32'(v_sync_out), 32'(exp_vs));
            end
            if (ph == 0) begin
                exp_hs  = hs;
                exp_vs  = vs;
                exp_unr = exp_unr | ~do_rom;
                chk("h_sync_load", 32'(h_sync_out), 32'(exp_hs));
                chk("v_sync_load", 32'(v_sync_out), 32'(exp_vs));
                chk("underrun", 32'(underrun), 32'(exp_unr));
                if (h_sync_out && !hso_prev)
                    chk("h_sync_delay", 32'(cyc - hs_rise_cyc), 32'd16);
                hso_prev = h_sync_out;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_video"},    32'(video),      32'd0);
        chk({tag, "_hs"},       32'(h_sync_out), 32'd0);
        chk({tag, "_vs"},       32'(v_sync_out), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun),   32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr),   32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        pixel_en = 1'b0; video_ram_strobe = 1'b0; video_rom_strobe = 1'b0;
        data_in = 8'h00; ra = 3'd0; graphic = 1'b0; invert = 1'b0;
        h_active = 1'b0; v_active = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
        repeat (3) @(negedge clk16);
        check_reset_state("por");
        reset_n = 1'b1;
        prime_queue();

        //        ha va hs vs inv gr ra    code   glyph  rom both bothv
        run_cell(1, 1, 0, 0, 0,  1, 3'd3, 8'h41, 8'hA5, 1,  0,   8'h00);
        run_cell(1, 1, 0, 0, 0,  0, 3'd0, 8'hC1, 8'hA5, 1,  0,   8'h00);
        run_cell(1, 1, 0, 0, 0,  0, 3'd5, 8'hC1, 8'hA5, 1,  0,   8'h00);
        run_cell(1, 1, 0, 0, 1,  0, 3'd1, 8'h01, 8'hA5, 1,  0,   8'h00);
        run_cell(1, 1, 1, 0, 1,  0, 3'd2, 8'h00, 8'hFF, 1,  0,   8'h00);
        run_cell(1, 1, 1, 1, 1,  1, 3'd7, 8'h7F, 8'h0F, 1,  0,   8'h00);
        run_cell(1, 0, 0, 1, 1,  0, 3'd0, 8'h00, 8'hFF, 1,  0,   8'h00);
        run_cell(1, 0, 0, 0, 1,  0, 3'd0, 8'h80, 8'hFF, 1,  0,   8'h00);
        run_cell(1, 1, 0, 0, 0,  0, 3'd4, 8'h80, 8'hA5, 1,  1,   8'h3C);
        run_cell(1, 1, 0, 0, 0,  0, 3'd0, 8'h00, 8'hFF, 0,  0,   8'h00);
        run_cell(1, 1, 1, 0, 0,  0, 3'd6, 8'h00, 8'hFF, 1,  0,   8'h00);
        run_cell(1, 1, 1, 1, 0,  1, 3'd1, 8'h55, 8'hFF, 1,  0,   8'h00);

        // Asynchronous reset between clock edges while lit, synced and flagged.
        pixel_en = 1'b0; video_ram_strobe = 1'b0; video_rom_strobe = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_state("async");
        repeat (2) @(negedge clk16);
        reset_n  = 1'b1;
        exp_hs   = 1'b0;
        exp_vs   = 1'b0;
        exp_unr  = 1'b0;
        hso_prev = 1'b0;
        h_active = 1'b0;
        v_active = 1'b0;
        prime_queue();

        run_cell(1, 1, 0, 0, 0,  0, 3'd2, 8'h12, 8'h3C, 1,  0,   8'h00);
        run_cell(1, 1, 0, 0, 1,  0, 3'd3, 8'h93, 8'h81, 1,  0,   8'h00);
        run_cell(0, 1, 0, 0, 0,  0, 3'd0, 8'h00, 8'h00, 1,  0,   8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
